nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs a wide (4*NIBBLES-bit) addition by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Latches operands on a start handshake, drives the slice's a/b/cin each cycle, captures its sum/cout, and presents the full result with a done pulse.
- Sits between a requesting unit and the shared 4-bit adder instance, which stays purely combinational.

---
 rtl/nibble_serial_add_ctrl.sv | 149 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder sequencer: feeds one shared combinational 4-bit adder slice one nibble
// per clock (LSB first) and publishes the full sum/carry atomically with a done pulse.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            last_s;
    logic [W-1:0]    a_reg_r;
    logic [W-1:0]    b_reg_r;
    logic [W-1:0]    work_r;
    logic [W-1:0]    work_s;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            cout_r;
    logic            busy_r;
    logic            done_r;
    logic [IW-1:0]   idx_r;

    assign last_s = (idx_r == IW'(NIBBLES - 1));

    // Next-state decode; a start in DONE is accepted exactly like one in IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s  = S_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_s  = S_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Slice operands come straight from the latched operands; forced to 0 outside RUN.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_r == S_RUN) begin
            add_a   = a_reg_r[4*idx_r +: 4];
            add_b   = b_reg_r[4*idx_r +: 4];
            add_cin = carry_r;
        end else begin
            add_a   = 4'd0;
            add_b   = 4'd0;
            add_cin = 1'b0;
        end
    end

    // Work value with the current slice result merged in, so the final nibble lands in sum.
    always_comb begin
        work_s = work_r;
        if (state_r == S_RUN) begin
            work_s[4*idx_r +: 4] = add_sum;
        end else begin
            work_s = work_r;
        end
    end

    // State, operand, work and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            a_reg_r <= '0;
            b_reg_r <= '0;
            work_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_RUN);
            done_r  <= (state_r == S_RUN) && last_s;
            if (accept_s) begin
                a_reg_r <= a;
                b_reg_r <= b;
                carry_r <= cin;
                work_r  <= '0;
                idx_r   <= '0;
            end else if (state_r == S_RUN) begin
                work_r  <= work_s;
                carry_r <= add_cout;
                idx_r   <= last_s ? '0 : idx_r + IW'(1);
                if (last_s) begin
                    sum_r  <= work_s;
                    cout_r <= add_cout;
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: directed operations push hand-computed {cout,sum}; monitors pop and
// compare on every done pulse. Covers a 4-nibble and a 1-nibble instance.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    logic        s_start;
    logic [3:0]  s_a;
    logic [3:0]  s_b;
    logic        s_cin;
    logic        s_busy;
    logic        s_done;
    logic [3:0]  s_sum;
    logic        s_cout;
    logic [3:0]  s_add_a;
    logic [3:0]  s_add_b;
    logic        s_add_cin;
    logic [3:0]  s_add_sum;
    logic        s_add_cout;

    int          pass_cnt;
    int          chk_cnt;
    logic [16:0] exp_q[$];
    logic [4:0]  exp1_q[$];
    logic [3:0]  cins;
    int          lat;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout),
        .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
        .add_sum(s_add_sum), .add_cout(s_add_cout)
    );

    // External 4-bit ripple slices shared with each controller
    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'd0, s_add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor for the 4-nibble instance
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_done: got done=1 expected no pending result");
            end else begin
                check("result4", {15'd0, cout, sum}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    // Monitor for the 1-nibble instance
    always @(negedge clk) begin
        if (s_done === 1'b1) begin
            if (exp1_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_done1: got done=1 expected no pending result");
            end else begin
                check("result1", {27'd0, s_cout, s_sum}, {27'd0, exp1_q.pop_front()});
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         input logic [16:0] expv);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the accept edge to done, recording add_cin and busy per RUN cycle.
    task automatic wait_done(input string nm, input int exp_lat);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        cins     = 4'd0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (cyc < 4) cins[cyc] = add_cin;
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        check({nm, "_latency"}, cyc, exp_lat);
        check({nm, "_busy_cycles"}, busy_cnt, exp_lat);
        check({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        pass_cnt = 0;
        chk_cnt  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = 16'd0;
        b        = 16'd0;
        cin      = 1'b0;
        s_start  = 1'b0;
        s_a      = 4'd0;
        s_b      = 4'd0;
        s_cin    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {15'd0, cout, sum}, 32'd0);
        check("rst_slice", {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with done pulse at E4, then done falls
        issue(16'h1234, 16'h0FFF, 1'b0, {1'b0, 16'h2233});
        wait_done("t1", 4);
        @(negedge clk);
        check("t1_done_falls", {31'd0, done}, 32'd0);
        check("t1_sum_holds", {16'd0, sum}, 32'h2233);

        // Full carry ripple; previous result stays visible while running
        issue(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});
        check("t2_sum_hold_running", {16'd0, sum}, 32'h2233);
        wait_done("t2", 4);
        check("t2_add_cin_seq", {28'd0, cins}, 32'b1110);
        @(negedge clk);

        // Max operands, then back-to-back start accepted in DONE
        issue(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
        wait_done("t3a", 4);
        issue(16'h0005, 16'h0003, 1'b1, {1'b0, 16'h0009});
        wait_done("t3b", 4);
        @(negedge clk);

        // Start while busy is ignored
        issue(16'h0100, 16'h0200, 1'b0, {1'b0, 16'h0300});
        @(negedge clk);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("t4_one_done", done_cnt, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset at idx=2 aborts and clears the result
        issue(16'h1111, 16'h2222, 1'b0, {1'b0, 16'h3333});
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        check("t5_rst_result", {15'd0, cout, sum}, 32'd0);
        check("t5_rst_slice", {23'd0, add_a, add_b, add_cin}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(16'h0007, 16'h0009, 1'b0, {1'b0, 16'h0010});
        wait_done("t5", 4);
        @(negedge clk);

        // Single-nibble instance: done at E1
        s_start = 1'b1;
        s_a     = 4'h9;
        s_b     = 4'h8;
        s_cin   = 1'b1;
        exp1_q.push_back({1'b1, 4'h2});
        @(negedge clk);
        s_start = 1'b0;
        check("t6_busy", {31'd0, s_busy}, 32'd1);
        @(negedge clk);
        check("t6_done_e1", {31'd0, s_done}, 32'd1);
        @(negedge clk);
        check("t6_done_falls", {31'd0, s_done}, 32'd0);

        check("pending4", exp_q.size(), 32'd0);
        check("pending1", exp1_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
